product_accumulator: RTL and testbench

Sequential accumulation stage directly downstream of the 16-bit scaled multiplier. It consumes one 16-bit unsigned product per accepted transfer and sums a burst of LENGTH products into a wide accumulator. It then presents the result, saturated to 16 bits, on a valid/ready output port. Typical use is forming dot products from the multiplier's `multiplier_output` stream.

---
 rtl/product_accumulator.sv | 101 ++++++++++
 tb/tb_product_accumulator.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a burst of LENGTH unsigned 16-bit products and presents the 16-bit saturated total.
// Result valid one cycle after the last accepted product; held in DONE until out_ready.
module product_accumulator #(
    parameter int LENGTH    = 8,
    parameter int ACC_WIDTH = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        overflow,
    output logic        busy,
    output logic [7:0]  count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_WIDTH-1:0] SAT_LIMIT = ACC_WIDTH'(16'hFFFF);
    localparam logic [7:0]           LAST_IDX  = 8'(LENGTH - 1);

    generate
        if (LENGTH < 1 || LENGTH > 256) begin : g_bad_length
            $error("product_accumulator: LENGTH must be in 1..256");
        end
        if (ACC_WIDTH < 16 + $clog2(LENGTH)) begin : g_bad_width
            $error("product_accumulator: ACC_WIDTH too narrow for LENGTH products");
        end
    endgenerate

    state_t                 r_state;
    state_t                 w_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [7:0]             r_count;
    logic                   w_clear;
    logic                   w_accept;
    logic                   w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_acc   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                r_acc   <= r_acc + ACC_WIDTH'(in_data);
                r_count <= r_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (r_count == LAST_IDX) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // For LENGTH=256 the 8-bit count wraps to 0 once the burst is full.
    assign w_sat     = (r_acc > SAT_LIMIT);
    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign count     = r_count;
    assign out_data  = out_valid ? (w_sat ? 16'hFFFF : r_acc[15:0]) : 16'h0000;
    assign overflow  = out_valid & w_sat;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator with LENGTH=4: directed scenarios plus randomized bursts.
module tb_product_accumulator;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        overflow;
    logic        busy;
    logic [7:0]  count;

    int checks = 0;
    int errors = 0;

    product_accumulator #(.LENGTH(LEN), .ACC_WIDTH(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sat16(input int s);
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_data, overflow, busy, count} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b dat=%h ovf=%b busy=%b cnt=%0d, required all 0",
                     in_ready, out_valid, out_data, overflow, busy, count);
        end
    endtask

    task automatic test_basic_sum();
        int lat;
        pulse_start();
        lat = 1;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: got busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
        for (int i = 1; i <= LEN; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            step();
            lat++;
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 30) begin
            step();
            lat++;
        end
        checks++;
        if (lat != LEN + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, required %0d", lat, LEN + 1);
        end
        checks++;
        if (out_data !== 16'd10 || overflow !== 1'b0 || count !== 8'(LEN) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got dat=%0d ovf=%b cnt=%0d rdy=%b, required 10 0 %0d 0",
                     out_data, overflow, count, in_ready, LEN);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0) begin
            errors++;
            $display("FAIL basic_handshake: got vld=%b busy=%b dat=%h, required 0 0 0000",
                     out_valid, busy, out_data);
        end
    endtask

    // Drives one full burst back-to-back from a 4-entry table and checks the result.
    task automatic run_table(input string name, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3, input logic [23:0] exp_acc);
        logic [15:0] tbl [4];
        int sum;
        tbl[0] = d0; tbl[1] = d1; tbl[2] = d2; tbl[3] = d3;
        sum = 0;
        pulse_start();
        for (int i = 0; i < LEN; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i];
            sum += int'(tbl[i]);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== sat16(sum) || overflow !== (sum > 65535)) begin
            errors++;
            $display("FAIL %s_result: got vld=%b dat=%h ovf=%b, required 1 %h %b",
                     name, out_valid, out_data, overflow, sat16(sum), (sum > 65535));
        end
        checks++;
        if (dut.r_acc !== exp_acc) begin
            errors++;
            $display("FAIL %s_acc: got %h, required %h", name, dut.r_acc, exp_acc);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        run_table("saturation", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 24'h03FFFC);
    endtask

    task automatic test_boundary();
        run_table("boundary", 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 24'h00FFFF);
    endtask

    task automatic test_gaps_backpressure();
        logic       vpat [7];
        logic [15:0] dq [$];
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        dq = '{16'd5, 16'd6, 16'd7, 16'd8};
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            in_valid = vpat[i];
            in_data  = vpat[i] ? dq.pop_front() : 16'hDEAD;
            step();
            if (i < 6) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL gaps_early_done: cycle %0d got vld=%b rdy=%b, required 0 1",
                             i, out_valid, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd26 || count !== 8'(LEN) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL gaps_stall: cycle %0d got vld=%b dat=%0d cnt=%0d ovf=%b, required 1 26 %0d 0",
                         i, out_valid, out_data, count, overflow, LEN);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_release: got vld=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_ignored_start();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(100 + i);
            step();
        end
        in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (count !== 8'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignored_start_accum: got cnt=%0d rdy=%b, required 2 1", count, in_ready);
        end
        for (int i = 2; i < LEN; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(100 + i);
            step();
        end
        in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd406 || count !== 8'(LEN)) begin
            errors++;
            $display("FAIL ignored_start_done: got vld=%b dat=%0d cnt=%0d, required 1 406 %0d",
                     out_valid, out_data, count, LEN);
        end
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || count !== 8'(LEN)) begin
            errors++;
            $display("FAIL ignored_start_handshake: got busy=%b rdy=%b cnt=%0d, required 0 0 %0d",
                     busy, in_ready, count, LEN);
        end
    endtask

    task automatic test_reset_mid_burst();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'd9;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_data, overflow, busy, count} !== 28'h0) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b dat=%h ovf=%b busy=%b cnt=%0d, required all 0",
                     in_ready, out_valid, out_data, overflow, busy, count);
        end
        pulse_start();
        for (int i = 0; i < LEN; i++) begin
            in_valid = 1'b1;
            in_data  = 16'd1;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_restart: got vld=%b dat=%0d ovf=%b, required 1 4 0",
                     out_valid, out_data, overflow);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random_bursts();
        int          sum;
        int          accepted;
        int          guard;
        int          stall;
        logic        v;
        logic [15:0] d;
        logic [15:0] exp_dat;
        logic        exp_ovf;
        for (int b = 0; b < 40; b++) begin
            sum = 0;
            accepted = 0;
            guard = 0;
            pulse_start();
            out_ready = 1'($urandom_range(0, 1));
            while (accepted < LEN && guard < 200) begin
                v = ($urandom_range(0, 2) != 0);
                d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 8'(accepted)) begin
                    errors++;
                    $display("FAIL random_accum: burst %0d got rdy=%b vld=%b cnt=%0d, required 1 0 %0d",
                             b, in_ready, out_valid, count, accepted);
                end
                in_valid = v;
                in_data  = d;
                if (v) begin
                    sum += int'(d);
                    accepted++;
                end
                step();
                guard++;
            end
            in_valid = 1'b0;
            exp_dat = sat16(sum);
            exp_ovf = (sum > 65535);
            stall = out_ready ? 0 : $urandom_range(0, 4);
            for (int s = 0; s <= stall; s++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_dat || overflow !== exp_ovf ||
                    count !== 8'(LEN) || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL random_done: burst %0d got vld=%b dat=%h ovf=%b cnt=%0d rdy=%b, required 1 %h %b %0d 0",
                             b, out_valid, out_data, overflow, count, in_ready, exp_dat, exp_ovf, LEN);
                end
                out_ready = (s == stall);
                step();
            end
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL random_idle: burst %0d got vld=%b busy=%b dat=%h ovf=%b, required 0 0 0000 0",
                         b, out_valid, busy, out_data, overflow);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_saturation();
        test_boundary();
        test_gaps_backpressure();
        test_ignored_start();
        test_reset_mid_burst();
        test_random_bursts();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
